// File: rtl/axis_fifo_wr_arbiter_pkg.sv
// Shared definitions for the AXI-Stream to async FIFO write arbiter:
// FSM state encoding and FIFO word field layout helpers. The field
// offsets are also meant for the read-side demultiplexer.
package axis_fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Bit position of the 'last' flag inside a FIFO word.
    function automatic int last_bit(input int data_width);
        return data_width;
    endfunction

    // LSB of the source-id field inside a FIFO word.
    function automatic int src_lsb(input int data_width);
        return data_width + 1;
    endfunction

    // Width of a source index; at least one bit.
    function automatic int src_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/axis_fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request found when searching
// upward from i_ptr, wrapping at N. Works for non-power-of-two N.
module axis_fifo_wr_arbiter_rr_pick
    import axis_fifo_wr_arbiter_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SRC_W = src_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SRC_W-1:0] i_ptr,
    output logic [SRC_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    logic [SRC_W:0]   w_sum;
    logic [SRC_W-1:0] w_idx;

    // Rotate the search start to i_ptr and take the first requester.
    always_comb begin
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            // i_ptr < N and k < N, so one subtraction is enough to wrap
            w_sum = {1'b0, i_ptr} + (SRC_W+1)'(k);
            if (w_sum >= (SRC_W+1)'(N)) begin
                w_idx = SRC_W'(w_sum - (SRC_W+1)'(N));
            end else begin
                w_idx = SRC_W'(w_sum);
            end
            if (!o_gnt_vld && i_req[w_idx]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = w_idx;
            end else begin
                o_gnt_vld = o_gnt_vld;
            end
        end
    end

endmodule

// File: rtl/axis_fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one async FIFO write port
// among NUM_SRC AXI-Stream sources. Each FIFO word is {src_id, last, data}.
// A grant is held until the granted source's last beat (or the forced
// beat at MAX_PKT_BEATS) is written; one idle cycle separates packets.
module axis_fifo_wr_arbiter
    import axis_fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_SRC       = 4,
    parameter  int DATA_WIDTH    = 32,
    parameter  int MAX_PKT_BEATS = 256,
    localparam int SRC_W         = src_width(NUM_SRC),
    localparam int FIFO_W        = SRC_W + 1 + DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [FIFO_W-1:0]             fifo_din,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic                          busy,
    output logic [SRC_W-1:0]              cur_src,
    output logic [31:0]                   pkt_cnt,
    output logic                          oversize_err
);

    localparam int              BEAT_W     = $clog2(MAX_PKT_BEATS) + 1;
    localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(MAX_PKT_BEATS - 1);
    localparam int              LAST_BIT   = last_bit(DATA_WIDTH);
    localparam int              SRC_LSB    = src_lsb(DATA_WIDTH);

    arb_state_t        r_state;
    logic [SRC_W-1:0]  r_grant;
    logic [SRC_W-1:0]  r_rr_ptr;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [31:0]       r_pkt_cnt;
    logic              r_oversize_err;

    logic [SRC_W-1:0]      w_pick_idx;
    logic                  w_pick_vld;
    logic                  w_in_lock;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_limit_hit;
    logic                  w_last_eff;
    logic                  w_accept;
    logic [NUM_SRC-1:0]    w_ready;
    logic [FIFO_W-1:0]     w_din;
    logic [SRC_W-1:0]      w_next_ptr;

    axis_fifo_wr_arbiter_rr_pick #(
        .N (NUM_SRC)
    ) u_rr_pick (
        .i_req     (s_axis_tvalid),
        .i_ptr     (r_rr_ptr),
        .o_gnt_idx (w_pick_idx),
        .o_gnt_vld (w_pick_vld)
    );

    assign w_in_lock = (r_state == ST_LOCK);

    // Granted-source mux, handshake and FIFO word assembly while locked.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_limit_hit = 1'b0;
        w_last_eff  = 1'b0;
        w_accept    = 1'b0;
        w_ready     = '0;
        w_din       = '0;
        if (w_in_lock) begin
            w_sel_valid = s_axis_tvalid[r_grant];
            w_sel_last  = s_axis_tlast[r_grant];
            w_sel_data  = s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
            w_limit_hit = (r_beat_cnt == BEAT_LIMIT);
            w_last_eff  = w_sel_last | w_limit_hit;
            w_accept    = w_sel_valid & ~fifo_full;
            // ready follows only the FIFO, so a dropped tvalid never loses the grant
            w_ready[r_grant]            = ~fifo_full;
            w_din[DATA_WIDTH-1:0]       = w_sel_data;
            w_din[LAST_BIT]             = w_last_eff;
            w_din[SRC_LSB +: SRC_W]     = r_grant;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Pointer to the source after the current grant, wrapping at NUM_SRC.
    always_comb begin
        w_next_ptr = '0;
        if (r_grant == SRC_W'(NUM_SRC - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = r_grant + SRC_W'(1);
        end
    end

    // Arbitration FSM with beat/packet counters and sticky oversize flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_grant        <= '0;
            r_rr_ptr       <= '0;
            r_beat_cnt     <= '0;
            r_pkt_cnt      <= '0;
            r_oversize_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant    <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= ST_LOCK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (w_accept) begin
                        if (w_last_eff) begin
                            r_beat_cnt <= '0;
                            r_pkt_cnt  <= r_pkt_cnt + 32'd1;
                            r_rr_ptr   <= w_next_ptr;
                            r_state    <= ST_IDLE;
                            // forced cut: remaining beats come back as a new packet
                            if (w_limit_hit && !w_sel_last) begin
                                r_oversize_err <= 1'b1;
                            end else begin
                                r_oversize_err <= r_oversize_err;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        end
                    end else begin
                        r_state <= ST_LOCK;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = w_ready;
    assign fifo_wr_en    = w_accept;
    assign fifo_din      = w_din;
    assign busy          = w_in_lock;
    assign cur_src       = r_grant;
    assign pkt_cnt       = r_pkt_cnt;
    assign oversize_err  = r_oversize_err;

endmodule

// File: tb/tb_axis_fifo_wr_arbiter.sv
// Self-checking bench for axis_fifo_wr_arbiter (4 sources, 32-bit data,
// 4-beat packet limit): a cycle table, a reset-mid-packet sequence and
// randomized traffic against a packet-level round-robin model.
module tb_axis_fifo_wr_arbiter;

    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int MAXB = 4;
    localparam int SW   = 2;
    localparam int FW   = SW + 1 + DW;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS*DW-1:0] tdata;
    logic [NS-1:0]    tvalid;
    logic [NS-1:0]    tlast;
    logic [NS-1:0]    tready;
    logic [FW-1:0]    din;
    logic             wr_en;
    logic             full;
    logic             busy;
    logic [SW-1:0]    cur;
    logic [31:0]      pkt;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;

    axis_fifo_wr_arbiter #(
        .NUM_SRC       (NS),
        .DATA_WIDTH    (DW),
        .MAX_PKT_BEATS (MAXB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tready (tready),
        .fifo_din      (din),
        .fifo_wr_en    (wr_en),
        .fifo_full     (full),
        .busy          (busy),
        .cur_src       (cur),
        .pkt_cnt       (pkt),
        .oversize_err  (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle-table record: inputs for one cycle and the outputs expected in it.
    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic [3:0] ready;
        logic       wr;
        logic [1:0] src;
        logic       lst;
        logic       bsy;
        logic [1:0] cur;
        int         pkt;
        logic       ovf;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                                input logic [3:0] r, input logic w, input logic [1:0] s,
                                input logic ls, input logic b, input logic [1:0] c,
                                input int p, input logic o);
        vec_t t;
        t.valid = v; t.last = l; t.full = f; t.ready = r; t.wr = w; t.src = s;
        t.lst = ls; t.bsy = b; t.cur = c; t.pkt = p; t.ovf = o;
        return t;
    endfunction

    function automatic logic [31:0] pat(input int s, input int step);
        return 32'hD000_0000 + 32'(s) * 32'h0001_0000 + 32'(step);
    endfunction

    task automatic drive_idle();
        tvalid = '0;
        tlast  = '0;
        tdata  = '0;
        full   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cur_src", 64'(cur), 64'd0);
        check("rst_pkt_cnt", 64'(pkt), 64'd0);
        check("rst_oversize", 64'(ovf), 64'd0);
        check("rst_din", 64'(din), 64'd0);
        rst = 1'b0;
    endtask

    // Random-test source storage: {last, data} per beat.
    logic [32:0]  smem [NS][16];
    int           slen [NS];
    int           shead[NS];
    logic [FW-1:0] exp_q[$];
    int           exp_pkts;
    logic         exp_ovf;

    // Packet-level reference: round-robin over sources with beats left,
    // each grant takes beats until tlast or MAXB beats, whichever first.
    task automatic build_model();
        int mh[NS];
        int ptr;
        int remaining;
        exp_q.delete();
        exp_pkts = 0;
        exp_ovf  = 1'b0;
        ptr      = 0;
        remaining = 0;
        for (int s = 0; s < NS; s++) begin
            mh[s] = 0;
            remaining += slen[s];
        end
        while (remaining > 0) begin
            int  g;
            int  cnt;
            logic done;
            g = -1;
            for (int k = 0; k < NS; k++) begin
                if (g < 0 && mh[(ptr + k) % NS] < slen[(ptr + k) % NS]) g = (ptr + k) % NS;
            end
            cnt  = 0;
            done = 1'b0;
            while (!done) begin
                logic [32:0] b;
                logic        le;
                b = smem[g][mh[g]];
                mh[g]++;
                remaining--;
                cnt++;
                le = b[32] || (cnt == MAXB);
                if (cnt == MAXB && !b[32]) exp_ovf = 1'b1;
                exp_q.push_back({2'(g), le, b[31:0]});
                done = le;
            end
            exp_pkts++;
            ptr = (g + 1) % NS;
        end
    endtask

    task automatic random_round(input int round);
        int   exp_idx;
        int   cyc;
        logic all_done;
        logic prev_last;
        for (int s = 0; s < NS; s++) begin
            slen[s]  = $urandom_range(1, 10);
            shead[s] = 0;
            for (int k = 0; k < slen[s]; k++) begin
                smem[s][k] = {(($urandom % 3) == 0) || (k == slen[s] - 1), 32'($urandom)};
            end
        end
        build_model();
        do_reset();
        exp_idx   = 0;
        cyc       = 0;
        all_done  = 1'b0;
        prev_last = 1'b0;
        while (!all_done && cyc < 3000) begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) begin
                if (shead[s] < slen[s]) begin
                    tvalid[s]          = 1'b1;
                    tlast[s]           = smem[s][shead[s]][32];
                    tdata[s*DW +: DW]  = smem[s][shead[s]][31:0];
                end else begin
                    tvalid[s]          = 1'b0;
                    tlast[s]           = 1'b0;
                    tdata[s*DW +: DW]  = '0;
                end
            end
            full = (($urandom % 4) == 0);
            #1;
            check("rand_single_ready", 64'($countones(tready) > 1), 64'd0);
            if (prev_last) check("rand_idle_bubble", 64'(wr_en), 64'd0);
            if (wr_en) begin
                if (exp_idx < exp_q.size()) begin
                    check($sformatf("rand_r%0d_word%0d", round, exp_idx), 64'(din), 64'(exp_q[exp_idx]));
                end else begin
                    check("rand_extra_write", 64'd1, 64'd0);
                end
                exp_idx++;
            end
            prev_last = wr_en && din[DW];
            for (int s = 0; s < NS; s++) begin
                if (tready[s] && tvalid[s]) shead[s]++;
            end
            all_done = 1'b1;
            for (int s = 0; s < NS; s++) begin
                if (shead[s] < slen[s]) all_done = 1'b0;
            end
            cyc++;
        end
        if (!all_done) check("rand_timeout", 64'd1, 64'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check("rand_write_count", 64'(exp_idx), 64'(exp_q.size()));
        check("rand_pkt_cnt", 64'(pkt), 64'(exp_pkts));
        check("rand_oversize", 64'(ovf), 64'(exp_ovf));
        check("rand_end_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();

        //             valid    last     f     ready    wr  src lst bsy cur pkt ovf
        tbl[0]  = mk(4'b0001, 4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 1, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(4'b0001, 4'b0000, 1'b1, 4'b0000, 0, 0, 0, 1, 0, 0, 0);
        tbl[3]  = mk(4'b0001, 4'b0001, 1'b0, 4'b0001, 1, 0, 1, 1, 0, 0, 0);
        tbl[4]  = mk(4'b0101, 4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(4'b0101, 4'b0000, 1'b0, 4'b0100, 1, 2, 0, 1, 2, 1, 0);
        tbl[6]  = mk(4'b0101, 4'b0000, 1'b0, 4'b0100, 1, 2, 0, 1, 2, 1, 0);
        tbl[7]  = mk(4'b0101, 4'b0000, 1'b0, 4'b0100, 1, 2, 0, 1, 2, 1, 0);
        tbl[8]  = mk(4'b0101, 4'b0000, 1'b0, 4'b0100, 1, 2, 1, 1, 2, 1, 0);
        tbl[9]  = mk(4'b0101, 4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 2, 2, 1);
        tbl[10] = mk(4'b0101, 4'b0001, 1'b0, 4'b0001, 1, 0, 1, 1, 0, 2, 1);
        tbl[11] = mk(4'b0100, 4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 3, 1);
        tbl[12] = mk(4'b0100, 4'b0100, 1'b0, 4'b0100, 1, 2, 1, 1, 2, 3, 1);
        tbl[13] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 2, 4, 1);
        tbl[14] = mk(4'b1000, 4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 2, 4, 1);
        tbl[15] = mk(4'b0000, 4'b0000, 1'b0, 4'b1000, 0, 0, 0, 1, 3, 4, 1);
        tbl[16] = mk(4'b1000, 4'b1000, 1'b0, 4'b1000, 1, 3, 1, 1, 3, 4, 1);
        tbl[17] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 3, 5, 1);

        do_reset();

        // Cycle table: single packet, stall, fairness, forced cut, tvalid drop.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            tvalid = tbl[i].valid;
            tlast  = tbl[i].last;
            full   = tbl[i].full;
            for (int s = 0; s < NS; s++) tdata[s*DW +: DW] = pat(s, i);
            #1;
            check($sformatf("tbl%0d_tready", i), 64'(tready), 64'(tbl[i].ready));
            check($sformatf("tbl%0d_wr_en", i), 64'(wr_en), 64'(tbl[i].wr));
            check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
            check($sformatf("tbl%0d_cur_src", i), 64'(cur), 64'(tbl[i].cur));
            check($sformatf("tbl%0d_pkt_cnt", i), 64'(pkt), 64'(tbl[i].pkt));
            check($sformatf("tbl%0d_oversize", i), 64'(ovf), 64'(tbl[i].ovf));
            if (tbl[i].wr) begin
                check($sformatf("tbl%0d_din_src", i), 64'(din[DW+1 +: SW]), 64'(tbl[i].src));
                check($sformatf("tbl%0d_din_last", i), 64'(din[DW]), 64'(tbl[i].lst));
                check($sformatf("tbl%0d_din_data", i), 64'(din[DW-1:0]), 64'(pat(int'(tbl[i].src), i)));
            end
        end

        // Reset mid-packet on source 3, then a fresh request from source 0 wins.
        @(negedge clk);
        drive_idle();
        tvalid = 4'b1000;
        #1;
        check("rstmid_idle_wr", 64'(wr_en), 64'd0);
        @(negedge clk);
        #1;
        check("rstmid_beat1_wr", 64'(wr_en), 64'd1);
        @(negedge clk);
        #1;
        check("rstmid_beat2_wr", 64'(wr_en), 64'd1);
        rst = 1'b1;
        #1;
        check("rstmid_tready", 64'(tready), 64'd0);
        check("rstmid_wr_en", 64'(wr_en), 64'd0);
        check("rstmid_pkt_cnt", 64'(pkt), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_oversize", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tvalid = 4'b1001;
        tlast  = 4'b0001;
        tdata[0 +: DW] = 32'h0000_C0DE;
        #1;
        check("rstmid_rearb_idle", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        check("rstmid_rearb_cur", 64'(cur), 64'd0);
        check("rstmid_rearb_wr", 64'(wr_en), 64'd1);
        check("rstmid_rearb_din", 64'(din), 64'({2'd0, 1'b1, 32'h0000_C0DE}));
        @(negedge clk);
        drive_idle();

        // Randomized traffic against the packet-level model.
        for (int r = 0; r < 6; r++) random_round(r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
